// File: rtl/fir_xifu_ex.sv
// Execute stage of the FIR X-interface unit: issues the LDTAP/LDSAM/STSAM memory
// request with a post-increment address and hands the updated pointer to WB.
// Single outstanding transaction; upstream stalls while memory or WB is pending.
// Optional build macro: FIR_XIFU_EX_MISALIGN_CHECK_EN (misaligned base goes
// straight to WB with wb_err_o set and no memory request).
module fir_xifu_ex #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [1:0]        id_instr_i,
  input  logic [ADDR_W-1:0] id_base_i,
  input  logic [11:0]       id_offset_i,
  input  logic              id_store_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rd_i,
  input  logic              id_kill_i,
  input  logic [DATA_W-1:0] ctrl_sample_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [1:0]        wb_instr_o,
  output logic [ADDR_W-1:0] wb_next_addr_o,
  output logic [4:0]        wb_rs1_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_err_o
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_t;

  state_t              state_q;
  logic [1:0]          instr_q;
  logic [ADDR_W-1:0]   base_q;
  logic [11:0]         offset_q;
  logic                store_q;
  logic [4:0]          rs1_q;
  logic [4:0]          rd_q;
  logic [DATA_W-1:0]   sample_q;
  logic [ADDR_W-1:0]   next_q;
  // Kill seen while the request was outstanding; result is dropped on grant.
  logic                kill_q;
`ifdef FIR_XIFU_EX_MISALIGN_CHECK_EN
  logic                err_q;
`endif

  logic                accept;
  logic [ADDR_W-1:0]   offset_ext;

  assign accept     = id_valid_i & id_ready_o;
  assign offset_ext = {{(ADDR_W-12){offset_q[11]}}, offset_q};

  // Control FSM and payload registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      instr_q  <= '0;
      base_q   <= '0;
      offset_q <= '0;
      store_q  <= 1'b0;
      rs1_q    <= '0;
      rd_q     <= '0;
      sample_q <= '0;
      next_q   <= '0;
      kill_q   <= 1'b0;
`ifdef FIR_XIFU_EX_MISALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StReq: begin
          // Request is never withdrawn; a kill only suppresses the WB result.
          if (mem_gnt_i) begin
            next_q  <= base_q + offset_ext;
            kill_q  <= 1'b0;
            state_q <= (kill_q | id_kill_i) ? StIdle : StHold;
          end else if (id_kill_i) begin
            kill_q <= 1'b1;
          end
        end
        StHold: begin
          if (!accept && (wb_ready_i || id_kill_i)) begin
            state_q <= StIdle;
          end
        end
        default: ;
      endcase

      // Acceptance happens only in IDLE or HOLD, so it never collides with REQ.
      if (accept) begin
        instr_q  <= id_instr_i;
        base_q   <= id_base_i;
        offset_q <= id_offset_i;
        store_q  <= id_store_i;
        rs1_q    <= id_rs1_i;
        rd_q     <= id_rd_i;
        sample_q <= ctrl_sample_i;
        kill_q   <= 1'b0;
        state_q  <= StReq;
`ifdef FIR_XIFU_EX_MISALIGN_CHECK_EN
        err_q    <= 1'b0;
        if (id_base_i[1:0] != 2'b00) begin
          err_q   <= 1'b1;
          next_q  <= id_base_i;
          state_q <= StHold;
        end
`endif
      end
    end
  end

  // Output decode from state; everything reads 0 while reset is asserted.
  always_comb begin
    id_ready_o     = 1'b0;
    mem_req_o      = 1'b0;
    mem_addr_o     = '0;
    mem_we_o       = 1'b0;
    mem_be_o       = 4'h0;
    mem_wdata_o    = '0;
    wb_valid_o     = 1'b0;
    wb_instr_o     = 2'b00;
    wb_next_addr_o = '0;
    wb_rs1_o       = '0;
    wb_rd_o        = '0;
    wb_err_o       = 1'b0;
    if (!rst_i) begin
      id_ready_o = (state_q == StIdle) | ((state_q == StHold) & wb_ready_i);
      case (state_q)
        StReq: begin
          mem_req_o   = 1'b1;
          mem_addr_o  = base_q;
          mem_we_o    = store_q;
          mem_be_o    = 4'hF;
          mem_wdata_o = store_q ? sample_q : '0;
        end
        StHold: begin
          wb_valid_o     = 1'b1;
          wb_instr_o     = instr_q;
          wb_next_addr_o = next_q;
          wb_rs1_o       = rs1_q;
          wb_rd_o        = rd_q;
`ifdef FIR_XIFU_EX_MISALIGN_CHECK_EN
          wb_err_o       = err_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_xifu_ex.sv
// Self-checking bench for fir_xifu_ex: transaction-level queue model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_fir_xifu_ex;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [1:0]  id_instr_i;
  logic [31:0] id_base_i;
  logic [11:0] id_offset_i;
  logic        id_store_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rd_i;
  logic        id_kill_i;
  logic [31:0] ctrl_sample_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [1:0]  wb_instr_o;
  logic [31:0] wb_next_addr_o;
  logic [4:0]  wb_rs1_o;
  logic [4:0]  wb_rd_o;
  logic        wb_err_o;

  fir_xifu_ex #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_instr_i(id_instr_i),
    .id_base_i(id_base_i), .id_offset_i(id_offset_i), .id_store_i(id_store_i),
    .id_rs1_i(id_rs1_i), .id_rd_i(id_rd_i), .id_kill_i(id_kill_i),
    .ctrl_sample_i(ctrl_sample_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_instr_o(wb_instr_o),
    .wb_next_addr_o(wb_next_addr_o), .wb_rs1_o(wb_rs1_o), .wb_rd_o(wb_rd_o),
    .wb_err_o(wb_err_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int total_cnt = 0;
  int req_cycles = 0;
  int wb_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    logic [1:0]  instr;
    logic [31:0] base;
    logic [11:0] off;
    logic        store;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [31:0] sample;
  } tx_t;

  typedef struct {
    logic [1:0]  instr;
    logic [31:0] next;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        err;
  } res_t;

  tx_t  req_q[$];
  res_t wb_q[$];
  bit   killed = 0;

  // Check at negedge, then apply what the coming posedge will do to the model.
  always @(negedge clk_i) begin
    if (rst_i) begin
      req_q.delete();
      wb_q.delete();
      killed = 0;
    end else begin
      bit   exp_ready;
      tx_t  t;
      res_t r;
      exp_ready = (req_q.size() == 0) && ((wb_q.size() == 0) || wb_ready_i);
      chk("id_ready", id_ready_o, exp_ready);
      chk("mem_req", mem_req_o, req_q.size() != 0);
      chk("wb_valid", wb_valid_o, wb_q.size() != 0);
      if (mem_req_o) req_cycles++;
      if (wb_valid_o) wb_cycles++;
      if (req_q.size() != 0) begin
        t = req_q[0];
        chk("mem_addr", mem_addr_o, t.base);
        chk("mem_we", mem_we_o, t.store);
        chk("mem_be", mem_be_o, 4'hF);
        chk("mem_wdata", mem_wdata_o, t.store ? t.sample : 32'h0);
      end
      if (wb_q.size() != 0) begin
        r = wb_q[0];
        chk("wb_instr", wb_instr_o, r.instr);
        chk("wb_next_addr", wb_next_addr_o, r.next);
        chk("wb_rs1", wb_rs1_o, r.rs1);
        chk("wb_rd", wb_rd_o, r.rd);
        chk("wb_err", wb_err_o, r.err);
        if (wb_ready_i || id_kill_i) void'(wb_q.pop_front());
      end
      if (req_q.size() != 0) begin
        if (id_kill_i) killed = 1;
        if (mem_gnt_i) begin
          t = req_q.pop_front();
          if (!killed) begin
            r.instr = t.instr;
            r.next  = t.base + 32'($signed(t.off));
            r.rs1   = t.rs1;
            r.rd    = t.rd;
            r.err   = 1'b0;
            wb_q.push_back(r);
          end
          killed = 0;
        end
      end
      if (id_valid_i && exp_ready) begin
        t.instr  = id_instr_i;
        t.base   = id_base_i;
        t.off    = id_offset_i;
        t.store  = id_store_i;
        t.rs1    = id_rs1_i;
        t.rd     = id_rd_i;
        t.sample = ctrl_sample_i;
        killed   = 0;
`ifdef FIR_XIFU_EX_MISALIGN_CHECK_EN
        if (t.base[1:0] != 2'b00) begin
          r.instr = t.instr;
          r.next  = t.base;
          r.rs1   = t.rs1;
          r.rd    = t.rd;
          r.err   = 1'b1;
          wb_q.push_back(r);
        end else begin
          req_q.push_back(t);
        end
`else
        req_q.push_back(t);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one instruction and hold it until accepted; returns 1 ns after the
  // accepting edge with id_valid_i low.
  task automatic issue(input logic [1:0] ins, input logic [31:0] base, input logic [11:0] off,
                       input logic st, input logic [4:0] rs1, input logic [4:0] rd,
                       input logic [31:0] smp);
    bit ok;
    ok = 0;
    id_valid_i = 1'b1; id_instr_i = ins; id_base_i = base; id_offset_i = off;
    id_store_i = st; id_rs1_i = rs1; id_rd_i = rd; ctrl_sample_i = smp;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_i);
      ok = id_ready_o;
      tick();
    end
    id_valid_i = 1'b0;
    chk("issue_accepted", ok, 1'b1);
  endtask

  task automatic wait_wb();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_i);
      ok = wb_valid_o;
    end
    chk("wb_valid_seen", ok, 1'b1);
  endtask

  int r0;
  int w0;

  initial begin
    rst_i = 1'b1; id_valid_i = 1'b0; id_instr_i = 2'b00; id_base_i = '0; id_offset_i = '0;
    id_store_i = 1'b0; id_rs1_i = '0; id_rd_i = '0; id_kill_i = 1'b0; ctrl_sample_i = '0;
    mem_gnt_i = 1'b0; wb_ready_i = 1'b0;

    // Reset state
    tick(); tick();
    @(negedge clk_i);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_id_ready", id_ready_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_wb_next", wb_next_addr_o, 32'h0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_id_ready", id_ready_o, 1'b1);
    tick();

    // LDTAP, grant with request, WB ready
    mem_gnt_i = 1'b1; wb_ready_i = 1'b1;
    issue(2'b00, 32'h0000_1000, 12'h004, 1'b0, 5'd3, 5'd7, 32'h0);
    @(negedge clk_i);
    chk("t1_req", mem_req_o, 1'b1);
    chk("t1_addr", mem_addr_o, 32'h0000_1000);
    chk("t1_we", mem_we_o, 1'b0);
    @(negedge clk_i);
    chk("t1_wb_valid", wb_valid_o, 1'b1);
    chk("t1_next", wb_next_addr_o, 32'h0000_1004);
    chk("t1_rd", wb_rd_o, 5'd7);
    tick();

    // STSAM, negative offset, grant delayed 3 cycles
    mem_gnt_i = 1'b0;
    r0 = req_cycles;
    issue(2'b11, 32'h0000_2000, 12'hFFC, 1'b1, 5'd4, 5'd0, 32'hDEAD_BEEF);
    @(negedge clk_i);
    chk("t2_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("t2_we", mem_we_o, 1'b1);
    chk("t2_id_ready", id_ready_o, 1'b0);
    tick(); tick(); tick();
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("t2_wb_valid", wb_valid_o, 1'b1);
    chk("t2_next", wb_next_addr_o, 32'h0000_1FFC);
    tick();
    chk("t2_req_cycles", req_cycles - r0, 4);

    // Address wrap
    issue(2'b00, 32'hFFFF_FFFC, 12'h008, 1'b0, 5'd1, 5'd2, 32'h0);
    wait_wb();
    chk("t3_next_wrap", wb_next_addr_o, 32'h0000_0004);
    tick();

    // Back-to-back LDSAM with WB stalled 2 cycles
    wb_ready_i = 1'b0;
    issue(2'b01, 32'h0000_3000, 12'h004, 1'b0, 5'd10, 5'd1, 32'h0);
    id_valid_i = 1'b1; id_instr_i = 2'b01; id_base_i = 32'h0000_3100; id_offset_i = 12'h008;
    id_store_i = 1'b0; id_rs1_i = 5'd11; id_rd_i = 5'd2;
    @(negedge clk_i);
    tick();
    @(negedge clk_i);
    chk("t4_hold1_next", wb_next_addr_o, 32'h0000_3004);
    chk("t4_hold1_ready", id_ready_o, 1'b0);
    tick();
    @(negedge clk_i);
    chk("t4_hold2_next", wb_next_addr_o, 32'h0000_3004);
    tick();
    wb_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t4_ready_same_cycle", id_ready_o, 1'b1);
    chk("t4_wb_valid", wb_valid_o, 1'b1);
    tick();
    id_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t4_req2", mem_req_o, 1'b1);
    chk("t4_addr2", mem_addr_o, 32'h0000_3100);
    @(negedge clk_i);
    chk("t4_next2", wb_next_addr_o, 32'h0000_3108);
    tick();

    // Kill in REQ before grant
    mem_gnt_i = 1'b0;
    w0 = wb_cycles;
    issue(2'b00, 32'h0000_4000, 12'h004, 1'b0, 5'd5, 5'd6, 32'h0);
    id_kill_i = 1'b1;
    tick();
    id_kill_i = 1'b0;
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("t5_req_held", mem_req_o, 1'b1);
    tick(); tick(); tick();
    chk("t5_no_wb", wb_cycles - w0, 0);
    chk("t5_idle_req", mem_req_o, 1'b0);

    // Kill in HOLD
    wb_ready_i = 1'b0;
    issue(2'b00, 32'h0000_5000, 12'h004, 1'b0, 5'd5, 5'd6, 32'h0);
    @(negedge clk_i);
    tick();
    id_kill_i = 1'b1;
    @(negedge clk_i);
    chk("t6_wb_before_kill", wb_valid_o, 1'b1);
    tick();
    id_kill_i = 1'b0;
    @(negedge clk_i);
    chk("t6_wb_dropped", wb_valid_o, 1'b0);
    chk("t6_idle_ready", id_ready_o, 1'b1);
    tick();
    wb_ready_i = 1'b1;

    // Misaligned base
    r0 = req_cycles;
    issue(2'b01, 32'h0000_1002, 12'h004, 1'b0, 5'd8, 5'd9, 32'h0);
`ifdef FIR_XIFU_EX_MISALIGN_CHECK_EN
    wait_wb();
    chk("t7_err", wb_err_o, 1'b1);
    chk("t7_next_base", wb_next_addr_o, 32'h0000_1002);
    tick();
    chk("t7_no_req", req_cycles - r0, 0);
`else
    @(negedge clk_i);
    chk("t7_addr_as_is", mem_addr_o, 32'h0000_1002);
    wait_wb();
    chk("t7_err", wb_err_o, 1'b0);
    chk("t7_next", wb_next_addr_o, 32'h0000_1006);
    tick();
`endif

    // Reset asserted during REQ
    mem_gnt_i = 1'b0;
    issue(2'b00, 32'h0000_6000, 12'h004, 1'b0, 5'd1, 5'd1, 32'h0);
    #2;
    chk("t8_req_before_rst", mem_req_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("t8_req_rst", mem_req_o, 1'b0);
    chk("t8_addr_rst", mem_addr_o, 32'h0);
    chk("t8_wb_rst", wb_valid_o, 1'b0);
    tick();
    rst_i = 1'b0;
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("t8_idle_after", id_ready_o, 1'b1);
    chk("t8_no_req_after", mem_req_o, 1'b0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
